// File: rtl/fft_butterfly_radix_4_inverse.sv
// Radix-4 inverse-FFT butterfly (conjugate twiddle direction). The datapath has three pipeline stages:
// partial sums, full sums, then scale/round/saturate. It uses valid/ready flow control and a sticky overflow flag.
module fft_butterfly_radix_4_inverse #(
  parameter int data_width_p = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic [1:0]                     x_scale,
  input  logic signed [data_width_p-1:0] x_a_re,
  input  logic signed [data_width_p-1:0] x_a_im,
  input  logic signed [data_width_p-1:0] x_b_re,
  input  logic signed [data_width_p-1:0] x_b_im,
  input  logic signed [data_width_p-1:0] x_c_re,
  input  logic signed [data_width_p-1:0] x_c_im,
  input  logic signed [data_width_p-1:0] x_d_re,
  input  logic signed [data_width_p-1:0] x_d_im,
  output logic                           y_valid,
  input  logic                           y_ready,
  output logic signed [data_width_p-1:0] y_a_re,
  output logic signed [data_width_p-1:0] y_a_im,
  output logic signed [data_width_p-1:0] y_b_re,
  output logic signed [data_width_p-1:0] y_b_im,
  output logic signed [data_width_p-1:0] y_c_re,
  output logic signed [data_width_p-1:0] y_c_im,
  output logic signed [data_width_p-1:0] y_d_re,
  output logic signed [data_width_p-1:0] y_d_im,
  input  logic                           cr_clear_overflow,
  output logic                           sr_overflow
);

  localparam int W = data_width_p;
  localparam logic signed [W+2:0] MAX_V = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] MIN_V = {4'b1111, {(W-1){1'b0}}};

  function automatic logic signed [W:0] ext1(input logic signed [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic signed [W+1:0] ext2(input logic signed [W:0] v);
    return {v[W], v};
  endfunction

  logic en;
  assign en      = !y_valid || y_ready;
  assign x_ready = en;

  logic                  v1, v2;
  logic [1:0]            s1_scale, s2_scale;
  logic signed [W:0]     ac_sum_re, ac_sum_im, ac_dif_re, ac_dif_im;
  logic signed [W:0]     bd_sum_re, bd_sum_im, bd_dif_re, bd_dif_im;
  logic [7:0][W+1:0]     s2_sum;
  logic [7:0][W-1:0]     y_out;
  logic                  y_ovf;

  logic signed [W+2:0]   bias;
  logic signed [W+2:0]   rounded [8];
  logic [7:0][W-1:0]     sat_val;
  logic [7:0]            clip;

  // Stage 3 combinational: round-half-up bias, arithmetic shift, clamp to output range.
  always_comb begin
    bias    = '0;
    clip    = '0;
    sat_val = '0;
    if (s2_scale == 2'd1)
      bias[0] = 1'b1;
    else if (s2_scale == 2'd2)
      bias[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rounded[k] = ($signed({s2_sum[k][W+1], s2_sum[k]}) + bias) >>> s2_scale;
      if (rounded[k] > MAX_V) begin
        sat_val[k] = MAX_V[W-1:0];
        clip[k]    = 1'b1;
      end else if (rounded[k] < MIN_V) begin
        sat_val[k] = MIN_V[W-1:0];
        clip[k]    = 1'b1;
      end else begin
        sat_val[k] = rounded[k][W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      y_valid   <= 1'b0;
      s1_scale  <= '0;
      s2_scale  <= '0;
      ac_sum_re <= '0;
      ac_sum_im <= '0;
      ac_dif_re <= '0;
      ac_dif_im <= '0;
      bd_sum_re <= '0;
      bd_sum_im <= '0;
      bd_dif_re <= '0;
      bd_dif_im <= '0;
      s2_sum    <= '0;
      y_out     <= '0;
      y_ovf     <= 1'b0;
    end else if (en) begin
      v1        <= x_valid;
      s1_scale  <= (x_scale == 2'd3) ? 2'd2 : x_scale;
      ac_sum_re <= ext1(x_a_re) + ext1(x_c_re);
      ac_sum_im <= ext1(x_a_im) + ext1(x_c_im);
      ac_dif_re <= ext1(x_a_re) - ext1(x_c_re);
      ac_dif_im <= ext1(x_a_im) - ext1(x_c_im);
      bd_sum_re <= ext1(x_b_re) + ext1(x_d_re);
      bd_sum_im <= ext1(x_b_im) + ext1(x_d_im);
      bd_dif_re <= ext1(x_b_re) - ext1(x_d_re);
      bd_dif_im <= ext1(x_b_im) - ext1(x_d_im);

      // Multiplying (b-d) by +/-j swaps re/im with a sign flip.
      v2        <= v1;
      s2_scale  <= s1_scale;
      s2_sum[0] <= ext2(ac_sum_re) + ext2(bd_sum_re);
      s2_sum[1] <= ext2(ac_sum_im) + ext2(bd_sum_im);
      s2_sum[2] <= ext2(ac_dif_re) - ext2(bd_dif_im);
      s2_sum[3] <= ext2(ac_dif_im) + ext2(bd_dif_re);
      s2_sum[4] <= ext2(ac_sum_re) - ext2(bd_sum_re);
      s2_sum[5] <= ext2(ac_sum_im) - ext2(bd_sum_im);
      s2_sum[6] <= ext2(ac_dif_re) + ext2(bd_dif_im);
      s2_sum[7] <= ext2(ac_dif_im) - ext2(bd_dif_re);

      y_valid   <= v2;
      y_out     <= sat_val;
      y_ovf     <= |clip;
    end
  end

  // Set on transfer of a clipped vector takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sr_overflow <= 1'b0;
    else if (y_valid && y_ready && y_ovf)
      sr_overflow <= 1'b1;
    else if (cr_clear_overflow)
      sr_overflow <= 1'b0;
  end

  assign y_a_re = y_out[0];
  assign y_a_im = y_out[1];
  assign y_b_re = y_out[2];
  assign y_b_im = y_out[3];
  assign y_c_re = y_out[4];
  assign y_c_im = y_out[5];
  assign y_d_re = y_out[6];
  assign y_d_im = y_out[7];

endmodule
